sfq_toggle_deser: RTL and testbench

SFQ_TOGGLE_DESER -- requirements
Module: sfq_toggle_deser

---
 rtl/sfq_toggle_deser.sv | 148 ++++++++++++++
 tb/tb_sfq_toggle_deser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfq_toggle_deser.sv
// rtl/sfq_toggle_deser.sv - toggle-encoded SFQ clock/data deserializer
// Recovers pulses from toggle lines, assembles slot bits into words, buffers in a 2-entry FIFO.
module sfq_toggle_deser #(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sfq_clk_in,
  input  logic              sfq_in,
  input  logic              clr_err,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  output logic              multi_pulse
);

  localparam int CW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);
  localparam logic [MW-1:0] MASK_END = MW'(SYNC_STAGES + 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t                 state, state_next;
  logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
  logic                   clk_prev, dat_prev;
  logic [MW-1:0]          mask_cnt;
  logic                   armed;
  logic                   clk_pulse, dat_pulse;
  logic                   slot_close;
  logic                   pending;
  logic [CW-1:0]          bit_cnt;
  logic [WORD_W-1:0]      shreg;
  logic [WORD_W-1:0]      done_word;
  logic                   bit_val;
  logic                   complete;
  logic                   multi_set;
  logic [WORD_W-1:0]      mem [2];
  logic                   wr_ptr, rd_ptr;
  logic [1:0]             count;
  logic                   full, push, pop, drop;

  // Previous registers keep following the synchronizers while masked, so the
  // reset-time settling of the chain never looks like a transition.
  assign armed     = (mask_cnt == MASK_END);
  assign clk_pulse = armed & (clk_sync[SYNC_STAGES-1] ^ clk_prev);
  assign dat_pulse = armed & (dat_sync[SYNC_STAGES-1] ^ dat_prev);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync <= '0;
      dat_sync <= '0;
      clk_prev <= 1'b0;
      dat_prev <= 1'b0;
      mask_cnt <= '0;
    end else begin
      clk_sync <= {clk_sync[SYNC_STAGES-2:0], sfq_clk_in};
      dat_sync <= {dat_sync[SYNC_STAGES-2:0], sfq_in};
      clk_prev <= clk_sync[SYNC_STAGES-1];
      dat_prev <= dat_sync[SYNC_STAGES-1];
      if (!armed) mask_cnt <= mask_cnt + MW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= PRIME;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    slot_close = 1'b0;
    case (state)
      PRIME:   if (clk_pulse) state_next = RUN;
      RUN:     slot_close = clk_pulse;
      default: state_next = PRIME;
    endcase
  end

  // A data pulse coincident with the clock pulse belongs to the slot being closed.
  assign bit_val   = pending | dat_pulse;
  assign done_word = shreg | (WORD_W'(bit_val) << bit_cnt);
  assign complete  = slot_close && (bit_cnt == LAST_BIT);
  assign multi_set = (state == RUN) && dat_pulse && pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (slot_close) begin
      pending <= 1'b0;
      if (complete) begin
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        bit_cnt <= bit_cnt + CW'(1);
        shreg   <= done_word;
      end
    end else if ((state == RUN) && dat_pulse) begin
      pending <= 1'b1;
    end
  end

  assign full       = (count == 2'd2);
  assign pop        = word_valid & word_ready;
  assign push       = complete & (~full | pop);
  assign drop       = complete & full & ~pop;
  assign word_valid = (count != 2'd0);
  assign word_data  = mem[rd_ptr];

  // When full with a simultaneous pop, the write lands in the slot being vacated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= done_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow    <= 1'b0;
      multi_pulse <= 1'b0;
    end else begin
      if (drop)         overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (multi_set)    multi_pulse <= 1'b1;
      else if (clr_err) multi_pulse <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sfq_toggle_deser.sv
// tb/tb_sfq_toggle_deser.sv - scoreboard bench for sfq_toggle_deser
// Slots are 10 clk long; data toggles sit 3 (and 5) clk into a slot.
module tb_sfq_toggle_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sfq_clk_in = 1'b0;
  logic       sfq_in = 1'b0;
  logic       clr_err = 1'b0;
  logic       word_ready = 1'b0;
  logic [7:0] word_data;
  logic       word_valid;
  logic       overflow;
  logic       multi_pulse;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         got_rd = 0;
  int         valid_cycles = 0;

  sfq_toggle_deser #(.WORD_W(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .sfq_clk_in(sfq_clk_in), .sfq_in(sfq_in),
    .clr_err(clr_err), .word_data(word_data), .word_valid(word_valid),
    .word_ready(word_ready), .overflow(overflow), .multi_pulse(multi_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (word_valid) valid_cycles <= valid_cycles + 1;
      if (word_valid && word_ready) got_q.push_back(word_data);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic din);
    rst_n = 1'b0;
    sfq_in = din;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    exp_q.delete();
    got_rd = got_q.size();
  endtask

  task automatic prime();
    tick(2);
    sfq_clk_in = ~sfq_clk_in;
  endtask

  // Each slot ends with the clock toggle that closes it (and opens the next).
  task automatic send_slots(input int n, input logic [7:0] one, input logic [7:0] two,
                            input logic [7:0] coin);
    for (int i = 0; i < n; i++) begin
      tick(3);
      if (one[i] || two[i]) sfq_in = ~sfq_in;
      tick(2);
      if (two[i]) sfq_in = ~sfq_in;
      tick(5);
      if (coin[i]) sfq_in = ~sfq_in;
      sfq_clk_in = ~sfq_clk_in;
    end
  endtask

  task automatic wait_words(input int n, output bit ok);
    int cyc = 0;
    while ((got_q.size() - got_rd) < n && cyc < 400) begin
      tick(1);
      cyc++;
    end
    ok = ((got_q.size() - got_rd) >= n);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", word_valid); end
    checks++; if (word_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", word_data); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
    checks++; if (multi_pulse !== 1'b0) begin failures++; $display("FAIL reset_multi got=%b exp=0", multi_pulse); end
    do_reset(1'b0);
  endtask

  task automatic test_single_word();
    bit ok;
    int vc0;
    word_ready = 1'b1;
    vc0 = valid_cycles;
    prime();
    exp_q.push_back(8'h85);
    send_slots(8, 8'h85, 8'h00, 8'h00);
    wait_words(1, ok);
    tick(5);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout got=%0d words exp=1", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL single_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
    checks++; if (valid_cycles - vc0 != 1) begin failures++; $display("FAIL single_valid_len got=%0d exp=1", valid_cycles - vc0); end
    checks++; if ({overflow, multi_pulse} !== 2'b00) begin failures++; $display("FAIL single_flags got=%b exp=00", {overflow, multi_pulse}); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    exp_q.push_back(8'hA5);
    send_slots(8, 8'hA5, 8'h00, 8'h00);
    exp_q.push_back(8'h3C);
    send_slots(8, 8'h3C, 8'h00, 8'h00);
    wait_words(2, ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_timeout got=%0d words exp=2", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL b2b_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
  endtask

  task automatic test_overflow();
    bit ok;
    do_reset(1'b0);
    word_ready = 1'b0;
    prime();
    exp_q.push_back(8'h01);
    send_slots(8, 8'h01, 8'h00, 8'h00);
    exp_q.push_back(8'h02);
    send_slots(8, 8'h02, 8'h00, 8'h00);
    send_slots(8, 8'h03, 8'h00, 8'h00);
    tick(6);
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
    checks++; if (word_valid !== 1'b1) begin failures++; $display("FAIL ovf_valid got=%b exp=1", word_valid); end
    tick(3);
    checks++; if (word_data !== 8'h01) begin failures++; $display("FAIL ovf_stable got=%h exp=01", word_data); end
    word_ready = 1'b1;
    wait_words(2, ok);
    tick(5);
    checks++; if (!ok) begin failures++; $display("FAIL ovf_timeout got=%0d words exp=2", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL ovf_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL ovf_drained got=%b exp=0", word_valid); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_multi_pulse();
    bit ok;
    exp_q.push_back(8'h10);
    send_slots(8, 8'h00, 8'h10, 8'h00);
    wait_words(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL multi_timeout got=%0d words exp=1", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL multi_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
    checks++; if (multi_pulse !== 1'b1) begin failures++; $display("FAIL multi_flag got=%b exp=1", multi_pulse); end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    checks++; if (multi_pulse !== 1'b0) begin failures++; $display("FAIL multi_clear got=%b exp=0", multi_pulse); end
  endtask

  task automatic test_coincident();
    bit ok;
    exp_q.push_back(8'h02);
    send_slots(8, 8'h00, 8'h00, 8'h02);
    wait_words(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL coin_timeout got=%0d words exp=1", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL coin_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
    checks++; if (multi_pulse !== 1'b0) begin failures++; $display("FAIL coin_multi got=%b exp=0", multi_pulse); end
  endtask

  task automatic test_data_high_at_reset();
    bit ok;
    do_reset(1'b1);
    tick(20);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL dhigh_valid got=%b exp=0", word_valid); end
    checks++; if (multi_pulse !== 1'b0) begin failures++; $display("FAIL dhigh_multi got=%b exp=0", multi_pulse); end
    prime();
    exp_q.push_back(8'h5A);
    send_slots(8, 8'h5A, 8'h00, 8'h00);
    wait_words(1, ok);
    checks++; if (!ok) begin failures++; $display("FAIL dhigh_timeout got=%0d words exp=1", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL dhigh_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
  endtask

  task automatic test_midword_reset();
    bit ok;
    send_slots(5, 8'h1F, 8'h00, 8'h00);
    tick(2);
    do_reset(1'b0);
    checks++; if (word_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", word_valid); end
    prime();
    exp_q.push_back(8'h40);
    send_slots(8, 8'h40, 8'h00, 8'h00);
    wait_words(1, ok);
    tick(10);
    checks++; if (got_q.size() - got_rd != 1) begin failures++; $display("FAIL mid_count got=%0d exp=1", got_q.size() - got_rd); end
    while (ok && exp_q.size() > 0 && got_rd < got_q.size()) begin
      checks++;
      if (got_q[got_rd] !== exp_q[0]) begin failures++; $display("FAIL mid_word got=%h exp=%h", got_q[got_rd], exp_q[0]); end
      got_rd++; void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_overflow();
    test_multi_pulse();
    test_coincident();
    test_data_high_at_reset();
    test_midword_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
